push_rpu_mway: RTL and testbench

- Parametrised successor push unit for the SRAM-backed BMW PIFO tree. Generalises the fixed 4-way, fixed-depth push engine to M-way fanout.
- Adds four behaviours:
  - a ready/valid handshake;
  - early termination when the element lands in an empty slot;
  - occupancy tracking with full/overflow flags;
  - pop-side decrement.
- Sits between the tree ingress arbiter and the per-level node SRAMs. The pop RPU shares the same SRAMs.

---
 rtl/bmw_pkg.sv | 46 ++++
 rtl/bmw_min_sel.sv | 29 ++
 rtl/push_rpu_mway.sv | 178 +++++++++++++++++
 tb/tb_push_rpu_mway.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmw_pkg.sv
// Shared definitions for the BMW PIFO tree push/pop units.
//   - push_state_e : push FSM states
//   - slot layout  : each slot is {cnt, meta, prio}, prio in the LSBs
//   - prio_sentinel: all-ones priority that marks an empty slot
//   - tree_cap     : total element capacity of an M-way, LEVEL-deep tree
package bmw_pkg;

    typedef enum logic {
        StIdle,
        StPush
    } push_state_e;

    localparam int unsigned PrioLsb = 0;

    function automatic int unsigned slot_width(input int unsigned ctw, input int unsigned mtw,
                                               input int unsigned ptw);
        return ctw + mtw + ptw;
    endfunction

    function automatic int unsigned meta_lsb(input int unsigned ptw);
        return ptw;
    endfunction

    function automatic int unsigned cnt_lsb(input int unsigned ptw, input int unsigned mtw);
        return ptw + mtw;
    endfunction

    // Right-aligned all-ones value; callers truncate to their priority width.
    function automatic logic [63:0] prio_sentinel(input int unsigned ptw);
        return {64{1'b1}} >> (64 - ptw);
    endfunction

    // Sum of M^k for k = 1..LEVEL, i.e. M*(M^LEVEL-1)/(M-1).
    function automatic int unsigned tree_cap(input int unsigned m, input int unsigned level);
        int unsigned acc;
        int unsigned pw;
        acc = 0;
        pw  = 1;
        for (int unsigned k = 0; k < level; k++) begin
            pw  = pw * m;
            acc = acc + pw;
        end
        return acc;
    endfunction

endpackage

// File: rtl/bmw_min_sel.sv
// M-input argmin over W-bit unsigned values, purely combinational.
// Ties resolve to the lowest index.
//   i_vals : M packed values, value i at [i*W +: W]
//   o_idx  : index of the smallest value
module bmw_min_sel #(
    parameter int unsigned M = 4,
    parameter int unsigned W = 8
) (
    input  logic [M*W-1:0]         i_vals,
    output logic [$clog2(M)-1:0]   o_idx
);

    localparam int unsigned IW = $clog2(M);

    logic [W-1:0] best;

    always_comb begin
        o_idx = '0;
        best  = i_vals[0 +: W];
        for (int i = 1; i < M; i++) begin
            // Strict compare keeps the earlier index on a tie.
            if (i_vals[i*W +: W] < best) begin
                best  = i_vals[i*W +: W];
                o_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/push_rpu_mway.sv
// M-way push unit for the SRAM-backed BMW PIFO tree.
// Descends from the root, at each level picking the slot with the smallest
// subtree count; the carried element swaps in when it has strictly smaller
// priority and the descent stops at the first empty slot (or the leaf level).
//   i_clk, i_arst_n                 : clock, async active-low reset
//   i_push/i_push_data/o_push_ready : ingress handshake, data = {meta, prio}
//   i_pop_done                      : one pulse per element removed by the pop unit
//   o_count/o_full/o_overflow       : occupancy, full flag, dropped-push pulse
//   o_read*/i_read_data             : node SRAM read port, 1-cycle latency
//   o_write*                        : node SRAM write port
module push_rpu_mway
    import bmw_pkg::*;
#(
    parameter int unsigned PTW   = 16,
    parameter int unsigned MTW   = 8,
    parameter int unsigned CTW   = 8,
    parameter int unsigned M     = 4,
    parameter int unsigned LEVEL = 3,
    parameter int unsigned ADW   = 16,
    parameter int unsigned OCW   = 16
) (
    input  logic                              i_clk,
    input  logic                              i_arst_n,
    input  logic                              i_push,
    input  logic [MTW+PTW-1:0]                i_push_data,
    output logic                              o_push_ready,
    input  logic                              i_pop_done,
    output logic [OCW-1:0]                    o_count,
    output logic                              o_full,
    output logic                              o_overflow,
    output logic                              o_read,
    output logic [$clog2(LEVEL)-1:0]          o_read_level,
    output logic [ADW-1:0]                    o_read_addr,
    input  logic [M*(CTW+MTW+PTW)-1:0]        i_read_data,
    output logic                              o_write,
    output logic [$clog2(LEVEL)-1:0]          o_write_level,
    output logic [ADW-1:0]                    o_write_addr,
    output logic [M*(CTW+MTW+PTW)-1:0]        o_write_data
);

    localparam int unsigned SW     = slot_width(CTW, MTW, PTW);
    localparam int unsigned KW     = MTW + PTW;
    localparam int unsigned IW     = $clog2(M);
    localparam int unsigned LW     = $clog2(LEVEL);
    localparam int unsigned CntLsb = cnt_lsb(PTW, MTW);
    localparam int unsigned CAP    = tree_cap(M, LEVEL);

    localparam logic [PTW-1:0] Sentinel  = PTW'(prio_sentinel(PTW));
    localparam logic [OCW-1:0] CapCount  = OCW'(CAP);
    localparam logic [LW-1:0]  LastLevel = LW'(LEVEL - 1);

    push_state_e      state_q, state_d;
    logic [LW-1:0]    level_q, level_d;
    logic [ADW-1:0]   addr_q, addr_d;
    logic [KW-1:0]    carry_q, carry_d;
    logic [OCW-1:0]   count_q, count_d;

    logic [M*CTW-1:0] slot_cnts;
    logic [IW-1:0]    sel_idx;
    logic [31:0]      sel_base;
    logic [SW-1:0]    sel_slot;
    logic [PTW-1:0]   slot_prio;
    logic [KW-1:0]    slot_key;
    logic [CTW-1:0]   slot_cnt;
    logic [SW-1:0]    new_slot;
    logic [ADW-1:0]   child_addr;

    logic is_push, slot_empty, take, last, done, full, accept;

    always_comb begin
        slot_cnts = '0;
        for (int i = 0; i < M; i++) begin
            slot_cnts[i*CTW +: CTW] = i_read_data[i*SW + CntLsb +: CTW];
        end
    end

    bmw_min_sel #(
        .M (M),
        .W (CTW)
    ) u_min_sel (
        .i_vals (slot_cnts),
        .o_idx  (sel_idx)
    );

    assign sel_base  = 32'(sel_idx) * SW;
    assign sel_slot  = i_read_data[sel_base +: SW];
    assign slot_prio = sel_slot[PrioLsb +: PTW];
    assign slot_key  = sel_slot[KW-1:0];
    assign slot_cnt  = sel_slot[CntLsb +: CTW];

    assign is_push    = (state_q == StPush);
    assign slot_empty = (slot_prio == Sentinel);
    // Strictly smaller wins, so equal priorities keep arrival order.
    assign take       = slot_empty | (carry_q[PTW-1:0] < slot_prio);
    assign last       = (level_q == LastLevel);
    assign done       = is_push & (slot_empty | last);

    assign full         = (count_q == CapCount);
    assign o_push_ready = ~full & (~is_push | done);
    assign accept       = i_push & o_push_ready;

    assign o_full     = full;
    assign o_overflow = i_push & full;
    assign o_count    = count_q;

    assign new_slot   = {slot_cnt + CTW'(1), take ? carry_q : slot_key};
    assign child_addr = (addr_q << IW) | ADW'(sel_idx);

    assign o_write       = is_push;
    assign o_write_level = level_q;
    assign o_write_addr  = addr_q;

    always_comb begin
        o_write_data = i_read_data;
        o_write_data[sel_base +: SW] = new_slot;
    end

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        addr_d       = addr_q;
        carry_d      = carry_q;
        o_read       = 1'b0;
        o_read_level = '0;
        o_read_addr  = '0;

        if (is_push && !done) begin
            o_read       = 1'b1;
            o_read_level = level_q + LW'(1);
            o_read_addr  = child_addr;
            level_d      = level_q + LW'(1);
            addr_d       = child_addr;
            if (take) begin
                carry_d = slot_key;
            end
        end else if (done) begin
            state_d = StIdle;
        end

        // Accept only happens in IDLE or the terminating cycle, so it never
        // collides with a descent read.
        if (accept) begin
            o_read       = 1'b1;
            o_read_level = '0;
            o_read_addr  = '0;
            state_d      = StPush;
            level_d      = '0;
            addr_d       = '0;
            carry_d      = i_push_data;
        end
    end

    always_comb begin
        count_d = count_q;
        if (accept && !i_pop_done) begin
            count_d = count_q + OCW'(1);
        end else if (!accept && i_pop_done && (count_q != '0)) begin
            count_d = count_q - OCW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= StIdle;
            level_q <= '0;
            addr_q  <= '0;
            carry_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            addr_q  <= addr_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_push_rpu_mway.sv
// Scoreboard bench for push_rpu_mway (M=4, LEVEL=3, CAP=84).
module tb_push_rpu_mway;

    localparam int PTW   = 16;
    localparam int MTW   = 8;
    localparam int CTW   = 8;
    localparam int M     = 4;
    localparam int LEVEL = 3;
    localparam int ADW   = 16;
    localparam int OCW   = 16;
    localparam int NW    = M * (CTW + MTW + PTW);

    localparam logic [31:0]   Es        = 32'h0000_FFFF;
    localparam logic [NW-1:0] EmptyNode = {4{Es}};

    typedef struct packed {
        logic [1:0]    lvl;
        logic [15:0]   addr;
        logic [NW-1:0] data;
    } wr_t;

    logic              i_clk = 1'b0;
    logic              i_arst_n = 1'b0;
    logic              i_push = 1'b0;
    logic [23:0]       i_push_data = '0;
    logic              o_push_ready;
    logic              i_pop_done = 1'b0;
    logic [OCW-1:0]    o_count;
    logic              o_full;
    logic              o_overflow;
    logic              o_read;
    logic [1:0]        o_read_level;
    logic [ADW-1:0]    o_read_addr;
    logic [NW-1:0]     i_read_data;
    logic              o_write;
    logic [1:0]        o_write_level;
    logic [ADW-1:0]    o_write_addr;
    logic [NW-1:0]     o_write_data;

    int  n_checks = 0;
    int  n_fail   = 0;
    logic sb_en    = 1'b0;
    logic mem_init = 1'b0;
    wr_t exp_q[$];
    wr_t mon_e;

    logic [NW-1:0] mem [0:LEVEL-1][0:15];
    logic [NW-1:0] rd_q;

    push_rpu_mway #(
        .PTW   (PTW),
        .MTW   (MTW),
        .CTW   (CTW),
        .M     (M),
        .LEVEL (LEVEL),
        .ADW   (ADW),
        .OCW   (OCW)
    ) dut (
        .i_clk         (i_clk),
        .i_arst_n      (i_arst_n),
        .i_push        (i_push),
        .i_push_data   (i_push_data),
        .o_push_ready  (o_push_ready),
        .i_pop_done    (i_pop_done),
        .o_count       (o_count),
        .o_full        (o_full),
        .o_overflow    (o_overflow),
        .o_read        (o_read),
        .o_read_level  (o_read_level),
        .o_read_addr   (o_read_addr),
        .i_read_data   (i_read_data),
        .o_write       (o_write),
        .o_write_level (o_write_level),
        .o_write_addr  (o_write_addr),
        .o_write_data  (o_write_data)
    );

    always #5 i_clk = ~i_clk;

    // Node SRAM model: 1-cycle read latency, write-first on a same-node collision.
    assign i_read_data = rd_q;
    always @(posedge i_clk) begin
        if (mem_init) begin
            for (int l = 0; l < LEVEL; l++) begin
                for (int a = 0; a < 16; a++) begin
                    mem[l][a] <= EmptyNode;
                end
            end
        end else begin
            if (o_write) begin
                mem[o_write_level][o_write_addr[3:0]] <= o_write_data;
            end
            if (o_read) begin
                if (o_write && o_write_level == o_read_level && o_write_addr == o_read_addr) begin
                    rd_q <= o_write_data;
                end else begin
                    rd_q <= mem[o_read_level][o_read_addr[3:0]];
                end
            end
        end
    end

    function automatic logic [31:0] slot(input logic [7:0] c, input logic [7:0] m,
                                         input logic [15:0] p);
        return {c, m, p};
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [1:0] lvl, input logic [15:0] addr,
                             input logic [NW-1:0] data);
        wr_t e;
        e.lvl  = lvl;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Write monitor: every SRAM write is matched against the next expectation.
    always @(negedge i_clk) begin
        if (sb_en && o_write) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got L%0d A%0h D%0h, expected no write",
                         o_write_level, o_write_addr, o_write_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("sram_write", {o_write_level, o_write_addr, o_write_data}, mon_e);
            end
        end
    end

    task automatic push(input logic [7:0] meta, input logic [15:0] prio);
        int guard;
        @(negedge i_clk);
        i_push      = 1'b1;
        i_push_data = {meta, prio};
        guard = 0;
        while (!o_push_ready && guard < 20) begin
            @(negedge i_clk);
            guard++;
        end
        if (!o_push_ready) begin
            check("push_ready_timeout", o_push_ready, 1'b1);
            i_push = 1'b0;
            return;
        end
        @(posedge i_clk);
        #1 i_push = 1'b0;
    endtask

    task automatic wait_idle();
        repeat (LEVEL + 1) @(negedge i_clk);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_arst_n   = 1'b0;
        i_push     = 1'b0;
        i_pop_done = 1'b0;
        mem_init   = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        mem_init = 1'b0;
        i_arst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge i_clk);
        mem_init = 1'b1;
        @(negedge i_clk);
        check("rst_ready", o_push_ready, 1'b1);
        check("rst_count", o_count, 16'd0);
        check("rst_full", o_full, 1'b0);
        check("rst_ovf", o_overflow, 1'b0);
        check("rst_rd_wr", {o_read, o_write}, 2'b00);
        mem_init = 1'b0;
        i_arst_n = 1'b1;
        sb_en    = 1'b1;

        // Empty tree: root slot0 takes the element in one cycle
        expect_wr(2'd0, 16'd0, {Es, Es, Es, slot(8'd1, 8'h01, 16'h0010)});
        push(8'h01, 16'h0010);
        @(negedge i_clk);
        check("p1_ready_term", o_push_ready, 1'b1);
        check("p1_write", o_write, 1'b1);
        @(negedge i_clk);
        check("p1_idle_rd_wr", {o_read, o_write}, 2'b00);
        check("p1_count", o_count, 16'd1);

        // Three back-to-back root pushes
        expect_wr(2'd0, 16'd0, {Es, Es, slot(8'd1, 8'h02, 16'h0020), slot(8'd1, 8'h01, 16'h0010)});
        expect_wr(2'd0, 16'd0, {Es, slot(8'd1, 8'h03, 16'h0030), slot(8'd1, 8'h02, 16'h0020),
                                slot(8'd1, 8'h01, 16'h0010)});
        expect_wr(2'd0, 16'd0, {slot(8'd1, 8'h04, 16'h0040), slot(8'd1, 8'h03, 16'h0030),
                                slot(8'd1, 8'h02, 16'h0020), slot(8'd1, 8'h01, 16'h0010)});
        push(8'h02, 16'h0020);
        push(8'h03, 16'h0030);
        push(8'h04, 16'h0040);
        wait_idle();
        check("p4_count", o_count, 16'd4);

        // 0x05 displaces 0x10 at the root; 0x10 lands in L1 node 0
        expect_wr(2'd0, 16'd0, {slot(8'd1, 8'h04, 16'h0040), slot(8'd1, 8'h03, 16'h0030),
                                slot(8'd1, 8'h02, 16'h0020), slot(8'd2, 8'h05, 16'h0005)});
        expect_wr(2'd1, 16'd0, {Es, Es, Es, slot(8'd1, 8'h01, 16'h0010)});
        push(8'h05, 16'h0005);
        @(negedge i_clk);
        check("p5_rd_l1", {o_read, o_read_level, o_read_addr}, {1'b1, 2'd1, 16'd0});
        check("p5_busy_ready", o_push_ready, 1'b0);
        wait_idle();
        check("p5_count", o_count, 16'd5);
        check("p5_sb_drained", exp_q.size(), 0);

        // Equal priority keeps the root slot, new element goes below
        do_reset();
        expect_wr(2'd0, 16'd0, {Es, Es, Es, slot(8'd1, 8'h01, 16'h0010)});
        expect_wr(2'd0, 16'd0, {Es, Es, slot(8'd1, 8'h02, 16'h0020), slot(8'd1, 8'h01, 16'h0010)});
        expect_wr(2'd0, 16'd0, {Es, slot(8'd1, 8'h03, 16'h0030), slot(8'd1, 8'h02, 16'h0020),
                                slot(8'd1, 8'h01, 16'h0010)});
        expect_wr(2'd0, 16'd0, {slot(8'd1, 8'h04, 16'h0040), slot(8'd1, 8'h03, 16'h0030),
                                slot(8'd1, 8'h02, 16'h0020), slot(8'd1, 8'h01, 16'h0010)});
        push(8'h01, 16'h0010);
        push(8'h02, 16'h0020);
        push(8'h03, 16'h0030);
        push(8'h04, 16'h0040);
        wait_idle();
        expect_wr(2'd0, 16'd0, {slot(8'd1, 8'h04, 16'h0040), slot(8'd1, 8'h03, 16'h0030),
                                slot(8'd1, 8'h02, 16'h0020), slot(8'd2, 8'h01, 16'h0010)});
        expect_wr(2'd1, 16'd0, {Es, Es, Es, slot(8'd1, 8'h06, 16'h0010)});
        push(8'h06, 16'h0010);
        wait_idle();
        check("eq_sb_drained", exp_q.size(), 0);

        // Reset in the L1 cycle: root cnts {2,1,1,1} -> slot1, 0x20 carried to L1 node 1
        expect_wr(2'd0, 16'd0, {slot(8'd1, 8'h04, 16'h0040), slot(8'd1, 8'h03, 16'h0030),
                                slot(8'd2, 8'h07, 16'h0005), slot(8'd2, 8'h01, 16'h0010)});
        push(8'h07, 16'h0005);
        @(negedge i_clk);
        check("rst_mid_rd_l1", {o_read, o_read_level, o_read_addr}, {1'b1, 2'd1, 16'd1});
        @(posedge i_clk);
        #1;
        check("rst_mid_wr_l1", {o_write, o_write_level, o_write_addr}, {1'b1, 2'd1, 16'd1});
        i_arst_n = 1'b0;
        #1;
        check("rst_mid_rd_wr", {o_read, o_write}, 2'b00);
        check("rst_mid_count", o_count, 16'd0);
        mem_init = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        mem_init = 1'b0;
        i_arst_n = 1'b1;
        #1;
        check("rst_rel_ready", o_push_ready, 1'b1);
        check("rst_rel_count", o_count, 16'd0);
        check("rst_sb_drained", exp_q.size(), 0);

        // Occupancy: simultaneous accept + pop leaves the count unchanged
        sb_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push(8'(i), 16'h0100 + 16'(i));
        end
        wait_idle();
        check("occ_count10", o_count, 16'd10);
        @(negedge i_clk);
        i_push      = 1'b1;
        i_push_data = {8'hAA, 16'h0200};
        i_pop_done  = 1'b1;
        check("occ_ready", o_push_ready, 1'b1);
        @(posedge i_clk);
        #1;
        i_push     = 1'b0;
        i_pop_done = 1'b0;
        @(negedge i_clk);
        check("occ_push_pop", o_count, 16'd10);
        wait_idle();

        // Fill to CAP
        for (int i = 0; i < 74; i++) begin
            push(8'(i), 16'h0300 + 16'(i));
        end
        wait_idle();
        check("full_count", o_count, 16'd84);
        check("full_flag", o_full, 1'b1);
        check("full_ready", o_push_ready, 1'b0);
        @(negedge i_clk);
        i_push      = 1'b1;
        i_push_data = {8'h55, 16'h0001};
        #1;
        check("ovf_pulse", o_overflow, 1'b1);
        check("ovf_no_sram", {o_read, o_write}, 2'b00);
        @(posedge i_clk);
        #1 i_push = 1'b0;
        @(negedge i_clk);
        check("ovf_clear", o_overflow, 1'b0);
        check("ovf_count", o_count, 16'd84);

        // Pop-side decrement and saturation at zero
        i_pop_done = 1'b1;
        @(negedge i_clk);
        i_pop_done = 1'b0;
        check("pop_count83", o_count, 16'd83);
        check("pop_not_full", o_full, 1'b0);
        check("pop_ready", o_push_ready, 1'b1);
        i_pop_done = 1'b1;
        repeat (83) @(negedge i_clk);
        i_pop_done = 1'b0;
        check("pop_count0", o_count, 16'd0);
        i_pop_done = 1'b1;
        @(negedge i_clk);
        i_pop_done = 1'b0;
        check("pop_saturate", o_count, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
